matmul_tile_scheduler: RTL and testbench

//  Breaks one large matmul command into SA_DIM x SA_DIM output tiles and issues one command per tile to
//  the systolic array core's command port, one tile at a time. Computes per-tile activation, weight and

---
 rtl/matmul_tile_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler: splits one host matmul command into DIM x DIM output tiles and
// issues them one at a time to the systolic array core, then reports the tile count.
module matmul_tile_scheduler #(
    parameter int unsigned SYSTOLIC_ARRAY_DIM = 8,
    parameter int unsigned DATA_WIDTH_BITS    = 16
) (
    input  logic        clock,
    input  logic        areset_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_act_addr,
    input  logic [63:0] cmd_wgt_addr,
    input  logic [63:0] cmd_out_addr,
    input  logic [19:0] cmd_inner_dimension,
    input  logic [15:0] cmd_m_tiles,
    input  logic [15:0] cmd_n_tiles,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_tiles_done,

    output logic        sa_cmd_valid,
    input  logic        sa_cmd_ready,
    output logic [63:0] sa_cmd_act_addr,
    output logic [63:0] sa_cmd_wgt_addr,
    output logic [63:0] sa_cmd_out_addr,
    output logic [19:0] sa_cmd_inner_dimension,

    input  logic        sa_resp_valid,
    output logic        sa_resp_ready,

    output logic        busy
);

    localparam int unsigned ElemBytes = DATA_WIDTH_BITS / 8;
    // Bytes per unit of K in one DIM-wide panel; K is scaled by this to get the panel stride.
    localparam logic [63:0] PanelScale = 64'(ElemBytes * SYSTOLIC_ARRAY_DIM);
    localparam logic [63:0] OutStride  = 64'(ElemBytes * SYSTOLIC_ARRAY_DIM * SYSTOLIC_ARRAY_DIM);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [63:0] act_q, act_d;
    logic [63:0] wgt_q, wgt_d;
    logic [63:0] out_q, out_d;
    logic [63:0] wgt_base_q, wgt_base_d;
    logic [63:0] pstride_q, pstride_d;
    logic [19:0] k_q, k_d;
    logic [15:0] m_q, m_d;
    logic [15:0] n_q, n_d;
    logic [15:0] m_tiles_q, m_tiles_d;
    logic [15:0] n_tiles_q, n_tiles_d;
    logic [31:0] count_q, count_d;

    logic last_m;
    logic last_n;

    assign last_m = (m_q == m_tiles_q - 16'd1);
    assign last_n = (n_q == n_tiles_q - 16'd1);

    // Command fields are driven straight from registers so they stay stable under backpressure.
    assign sa_cmd_act_addr        = act_q;
    assign sa_cmd_wgt_addr        = wgt_q;
    assign sa_cmd_out_addr        = out_q;
    assign sa_cmd_inner_dimension = k_q;
    assign resp_tiles_done        = count_q;

    // Next-state, running address updates and handshake outputs.
    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        wgt_d         = wgt_q;
        out_d         = out_q;
        wgt_base_d    = wgt_base_q;
        pstride_d     = pstride_q;
        k_d           = k_q;
        m_d           = m_q;
        n_d           = n_q;
        m_tiles_d     = m_tiles_q;
        n_tiles_d     = n_tiles_q;
        count_d       = count_q;
        cmd_ready     = 1'b0;
        sa_cmd_valid  = 1'b0;
        sa_resp_ready = 1'b0;
        resp_valid    = 1'b0;
        busy          = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // Gated so cmd_ready reads 0 while reset is held.
                cmd_ready = areset_n;
                if (cmd_valid) begin
                    act_d      = cmd_act_addr;
                    wgt_d      = cmd_wgt_addr;
                    wgt_base_d = cmd_wgt_addr;
                    out_d      = cmd_out_addr;
                    k_d        = cmd_inner_dimension;
                    m_tiles_d  = cmd_m_tiles;
                    n_tiles_d  = cmd_n_tiles;
                    pstride_d  = PanelScale * 64'(cmd_inner_dimension);
                    m_d        = 16'd0;
                    n_d        = 16'd0;
                    count_d    = 32'd0;
                    if (cmd_m_tiles == 16'd0 || cmd_n_tiles == 16'd0 ||
                        cmd_inner_dimension == 20'd0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                sa_cmd_valid = 1'b1;
                if (sa_cmd_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                sa_resp_ready = 1'b1;
                if (sa_resp_valid) begin
                    count_d = count_q + 32'd1;
                    // Output tiles are contiguous in (m,n) row-major order.
                    out_d   = out_q + OutStride;
                    if (last_m && last_n) begin
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                        if (last_n) begin
                            n_d   = 16'd0;
                            m_d   = m_q + 16'd1;
                            wgt_d = wgt_base_q;
                            act_d = act_q + pstride_q;
                        end else begin
                            n_d   = n_q + 16'd1;
                            wgt_d = wgt_q + pstride_q;
                        end
                    end
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched command, running addresses, tile indices and count.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            act_q      <= 64'd0;
            wgt_q      <= 64'd0;
            out_q      <= 64'd0;
            wgt_base_q <= 64'd0;
            pstride_q  <= 64'd0;
            k_q        <= 20'd0;
            m_q        <= 16'd0;
            n_q        <= 16'd0;
            m_tiles_q  <= 16'd0;
            n_tiles_q  <= 16'd0;
            count_q    <= 32'd0;
        end else begin
            act_q      <= act_d;
            wgt_q      <= wgt_d;
            out_q      <= out_d;
            wgt_base_q <= wgt_base_d;
            pstride_q  <= pstride_d;
            k_q        <= k_d;
            m_q        <= m_d;
            n_q        <= n_d;
            m_tiles_q  <= m_tiles_d;
            n_tiles_q  <= n_tiles_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler with a tile/response scoreboard.
module tb_matmul_tile_scheduler;

    logic        clock = 1'b0;
    logic        areset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_act_addr = 64'd0;
    logic [63:0] cmd_wgt_addr = 64'd0;
    logic [63:0] cmd_out_addr = 64'd0;
    logic [19:0] cmd_inner_dimension = 20'd0;
    logic [15:0] cmd_m_tiles = 16'd0;
    logic [15:0] cmd_n_tiles = 16'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_tiles_done;
    logic        sa_cmd_valid;
    logic        sa_cmd_ready = 1'b0;
    logic [63:0] sa_cmd_act_addr;
    logic [63:0] sa_cmd_wgt_addr;
    logic [63:0] sa_cmd_out_addr;
    logic [19:0] sa_cmd_inner_dimension;
    logic        sa_resp_valid = 1'b0;
    logic        sa_resp_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] act;
        logic [63:0] wgt;
        logic [63:0] out;
        logic [19:0] k;
    } tile_t;

    tile_t tile_q[$];
    int    resp_q[$];

    matmul_tile_scheduler #(
        .SYSTOLIC_ARRAY_DIM(8),
        .DATA_WIDTH_BITS   (16)
    ) dut (
        .clock                 (clock),
        .areset_n              (areset_n),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_act_addr          (cmd_act_addr),
        .cmd_wgt_addr          (cmd_wgt_addr),
        .cmd_out_addr          (cmd_out_addr),
        .cmd_inner_dimension   (cmd_inner_dimension),
        .cmd_m_tiles           (cmd_m_tiles),
        .cmd_n_tiles           (cmd_n_tiles),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_tiles_done       (resp_tiles_done),
        .sa_cmd_valid          (sa_cmd_valid),
        .sa_cmd_ready          (sa_cmd_ready),
        .sa_cmd_act_addr       (sa_cmd_act_addr),
        .sa_cmd_wgt_addr       (sa_cmd_wgt_addr),
        .sa_cmd_out_addr       (sa_cmd_out_addr),
        .sa_cmd_inner_dimension(sa_cmd_inner_dimension),
        .sa_resp_valid         (sa_resp_valid),
        .sa_resp_ready         (sa_resp_ready),
        .busy                  (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: closed-form tile addresses, independent of the RTL's running adders.
    task automatic push_job(input logic [63:0] act, input logic [63:0] wgt,
                            input logic [63:0] out, input logic [19:0] k,
                            input int m_t, input int n_t);
        logic [63:0] p;
        tile_t       t;
        p = 64'd16 * 64'(k);
        if (m_t == 0 || n_t == 0 || k == 20'd0) begin
            resp_q.push_back(0);
        end else begin
            for (int m = 0; m < m_t; m++) begin
                for (int n = 0; n < n_t; n++) begin
                    t.act = act + 64'(m) * p;
                    t.wgt = wgt + 64'(n) * p;
                    t.out = out + 64'(m * n_t + n) * 64'd128;
                    t.k   = k;
                    tile_q.push_back(t);
                end
            end
            resp_q.push_back(m_t * n_t);
        end
    endtask

    task automatic set_cmd(input logic [63:0] act, input logic [63:0] wgt,
                           input logic [63:0] out, input logic [19:0] k,
                           input int m_t, input int n_t);
        cmd_act_addr        = act;
        cmd_wgt_addr        = wgt;
        cmd_out_addr        = out;
        cmd_inner_dimension = k;
        cmd_m_tiles         = 16'(m_t);
        cmd_n_tiles         = 16'(n_t);
    endtask

    // Called at a negedge; returns at the negedge after the command fires.
    task automatic send_cmd();
        int c;
        c = 0;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && c < 100) begin
            @(negedge clock);
            c++;
        end
        check_bit("cmd_accept", cmd_ready, 1'b1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Core model: accepts and completes tiles, comparing each against the scoreboard.
    task automatic serve_tiles(input int count, input int cmd_stall, input int resp_delay);
        for (int i = 0; i < count; i++) begin
            tile_t e;
            int    c;
            c = 0;
            while (sa_cmd_valid !== 1'b1 && c < 100) begin
                @(negedge clock);
                c++;
            end
            check_bit("sa_cmd_valid", sa_cmd_valid, 1'b1);
            check_bit("sb_nonempty", tile_q.size() != 0, 1'b1);
            if (tile_q.size() == 0) return;
            e = tile_q.pop_front();
            for (int s = 0; s < cmd_stall; s++) begin
                check("stall_act", sa_cmd_act_addr, e.act);
                check("stall_wgt", sa_cmd_wgt_addr, e.wgt);
                check("stall_out", sa_cmd_out_addr, e.out);
                check_bit("stall_valid", sa_cmd_valid, 1'b1);
                check_bit("stall_cmd_ready", cmd_ready, 1'b0);
                check_bit("stall_busy", busy, 1'b1);
                @(negedge clock);
            end
            check("sa_act", sa_cmd_act_addr, e.act);
            check("sa_wgt", sa_cmd_wgt_addr, e.wgt);
            check("sa_out", sa_cmd_out_addr, e.out);
            check("sa_k", 64'(sa_cmd_inner_dimension), 64'(e.k));
            sa_cmd_ready = 1'b1;
            @(negedge clock);
            sa_cmd_ready = 1'b0;
            check_bit("wait_no_cmd", sa_cmd_valid, 1'b0);
            check_bit("wait_resp_ready", sa_resp_ready, 1'b1);
            for (int d = 0; d < resp_delay; d++) begin
                @(negedge clock);
                check_bit("delay_resp_ready", sa_resp_ready, 1'b1);
                check_bit("delay_cmd_ready", cmd_ready, 1'b0);
                check_bit("delay_busy", busy, 1'b1);
            end
            sa_resp_valid = 1'b1;
            @(negedge clock);
            sa_resp_valid = 1'b0;
            if (i + 1 < count) check_bit("next_issue_latency", sa_cmd_valid, 1'b1);
        end
    endtask

    task automatic get_resp(input int stall);
        int c;
        int exp;
        c = 0;
        while (resp_valid !== 1'b1 && c < 100) begin
            @(negedge clock);
            c++;
        end
        check_bit("resp_valid", resp_valid, 1'b1);
        check_bit("resp_sb_nonempty", resp_q.size() != 0, 1'b1);
        if (resp_q.size() == 0) return;
        exp = resp_q.pop_front();
        check("resp_tiles_done", 64'(resp_tiles_done), 64'(exp));
        for (int s = 0; s < stall; s++) begin
            check_bit("rstall_valid", resp_valid, 1'b1);
            check("rstall_done", 64'(resp_tiles_done), 64'(exp));
            check_bit("rstall_cmd_ready", cmd_ready, 1'b0);
            check_bit("rstall_busy", busy, 1'b1);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check_bit("post_resp_busy", busy, 1'b0);
        check_bit("post_resp_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_sa_cmd_valid"}, sa_cmd_valid, 1'b0);
        check_bit({tag, "_sa_resp_ready"}, sa_resp_ready, 1'b0);
        check_bit({tag, "_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_act"}, sa_cmd_act_addr, 64'd0);
        check({tag, "_wgt"}, sa_cmd_wgt_addr, 64'd0);
        check({tag, "_out"}, sa_cmd_out_addr, 64'd0);
        check({tag, "_k"}, 64'(sa_cmd_inner_dimension), 64'd0);
        check({tag, "_done"}, 64'(resp_tiles_done), 64'd0);
    endtask

    initial begin
        // Reset values.
        #2;
        check_all_zero("reset");
        @(negedge clock);
        areset_n = 1'b1;
        @(negedge clock);
        check_bit("idle_cmd_ready", cmd_ready, 1'b1);
        check_bit("idle_busy", busy, 1'b0);

        // 1: single tile.
        set_cmd(64'h1000, 64'h2000, 64'h3000, 20'd4, 1, 1);
        push_job(64'h1000, 64'h2000, 64'h3000, 20'd4, 1, 1);
        send_cmd();
        check_bit("issue_latency", sa_cmd_valid, 1'b1);
        serve_tiles(1, 0, 0);
        get_resp(0);

        // 2: 2x3 tiles, n inner.
        set_cmd(64'h1000, 64'h2000, 64'h3000, 20'd4, 2, 3);
        push_job(64'h1000, 64'h2000, 64'h3000, 20'd4, 2, 3);
        send_cmd();
        serve_tiles(6, 0, 0);
        get_resp(0);

        // 3: degenerate jobs produce no core commands.
        set_cmd(64'h1000, 64'h2000, 64'h3000, 20'd4, 0, 3);
        push_job(64'h1000, 64'h2000, 64'h3000, 20'd4, 0, 3);
        send_cmd();
        check_bit("m0_no_sa_cmd", sa_cmd_valid, 1'b0);
        check_bit("m0_resp_now", resp_valid, 1'b1);
        get_resp(0);
        set_cmd(64'h1000, 64'h2000, 64'h3000, 20'd0, 2, 2);
        push_job(64'h1000, 64'h2000, 64'h3000, 20'd0, 2, 2);
        send_cmd();
        check_bit("k0_no_sa_cmd", sa_cmd_valid, 1'b0);
        check_bit("k0_resp_now", resp_valid, 1'b1);
        get_resp(0);

        // 4: backpressure on every handshake.
        set_cmd(64'h4000, 64'h5000, 64'h6000, 20'd3, 1, 2);
        push_job(64'h4000, 64'h5000, 64'h6000, 20'd3, 1, 2);
        send_cmd();
        serve_tiles(2, 5, 20);
        get_resp(3);

        // Address wrap modulo 2^64.
        set_cmd(64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FF80,
                20'd4, 2, 2);
        push_job(64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FF80,
                 20'd4, 2, 2);
        send_cmd();
        serve_tiles(4, 0, 1);
        get_resp(0);

        // 5: reset while waiting on the third tile.
        set_cmd(64'h1000, 64'h2000, 64'h3000, 20'd4, 2, 2);
        push_job(64'h1000, 64'h2000, 64'h3000, 20'd4, 2, 2);
        send_cmd();
        serve_tiles(2, 0, 0);
        check_bit("t3_valid", sa_cmd_valid, 1'b1);
        check("t3_act", sa_cmd_act_addr, tile_q[0].act);
        check("t3_out", sa_cmd_out_addr, tile_q[0].out);
        sa_cmd_ready = 1'b1;
        @(negedge clock);
        sa_cmd_ready = 1'b0;
        check_bit("t3_waiting", sa_resp_ready, 1'b1);
        areset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tile_q.delete();
        resp_q.delete();
        @(negedge clock);
        areset_n = 1'b1;
        @(negedge clock);
        check_bit("post_reset_cmd_ready", cmd_ready, 1'b1);
        set_cmd(64'h7000, 64'h8000, 64'h9000, 20'd2, 1, 1);
        push_job(64'h7000, 64'h8000, 64'h9000, 20'd2, 1, 1);
        send_cmd();
        serve_tiles(1, 0, 0);
        get_resp(0);

        // 6: back-to-back jobs with cmd_valid held high.
        set_cmd(64'h1000, 64'h2000, 64'h3000, 20'd4, 1, 1);
        push_job(64'h1000, 64'h2000, 64'h3000, 20'd4, 1, 1);
        cmd_valid  = 1'b1;
        resp_ready = 1'b1;
        @(negedge clock);
        check_bit("b2b_first_busy", busy, 1'b1);
        check_bit("b2b_not_ready", cmd_ready, 1'b0);
        serve_tiles(1, 0, 0);
        check_bit("b2b_resp_valid", resp_valid, 1'b1);
        check("b2b_resp_done", 64'(resp_tiles_done), 64'(resp_q.pop_front()));
        set_cmd(64'hA000, 64'hB000, 64'hC000, 20'd5, 1, 1);
        push_job(64'hA000, 64'hB000, 64'hC000, 20'd5, 1, 1);
        @(negedge clock);
        check_bit("b2b_idle_ready", cmd_ready, 1'b1);
        check_bit("b2b_resp_dropped", resp_valid, 1'b0);
        @(negedge clock);
        cmd_valid  = 1'b0;
        resp_ready = 1'b0;
        check_bit("b2b_second_issue", sa_cmd_valid, 1'b1);
        serve_tiles(1, 0, 0);
        get_resp(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
